// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM state encoding,
// ROM word field layout and default widths.
package melody_pkg;

    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_PITCH_W   = 5;
    localparam int DEF_DUR_W     = 6;
    localparam int DEF_GAP_BEATS = 1;

    // ROM word is {pitch, beats}; beats occupies the low bits.
    localparam int BEATS_LSB = 0;

    // A beats field of zero marks end-of-song.
    localparam int END_BEATS = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    function automatic int pitch_lsb(input int dur_w);
        return BEATS_LSB + dur_w;
    endfunction

endpackage

// File: rtl/note_timer.sv
// Beat counter shared by note and gap timing; done fires combinationally on
// the tick that completes `target` beats.
module note_timer
    import melody_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick_en,
    input  logic [DUR_W-1:0] target,
    output logic             done
);

    logic [DUR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= cnt + DUR_W'(1);
        end
    end

    assign done = tick_en && (cnt == (target - DUR_W'(1)));

endmodule

// File: rtl/melody_sequencer.sv
// Song-level controller: walks the melody ROM, drives pitch/enable to the tone
// divider and times each note (plus optional silent gap) in beat ticks.
//
// state | meaning
// IDLE  | stopped, waiting for play
// FETCH | rom_addr stable, waiting out the registered ROM latency
// LOAD  | decode ROM word: start a note or handle the END marker
// PLAY  | note sounding, counting its beats
// GAP   | silent articulation beats after a note
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PITCH_W   = DEF_PITCH_W,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int GAP_BEATS = DEF_GAP_BEATS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat_tick,
    input  logic                     play,
    input  logic                     pause,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [PITCH_W+DUR_W-1:0] rom_data,
    output logic [PITCH_W-1:0]       note_code,
    output logic                     note_valid,
    output logic                     note_change,
    output logic                     playing,
    output logic                     song_done
);

    localparam int PITCH_LSB = pitch_lsb(DUR_W);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [PITCH_W-1:0] code_n;
    logic               note_on, on_n;
    logic               change_n;
    logic               done_n;
    logic [DUR_W-1:0]   note_beats, beats_n;

    logic [DUR_W-1:0]   rom_beats;
    logic [PITCH_W-1:0] rom_pitch;
    logic               timing;
    logic               tick_en;
    logic               timer_clear;
    logic               timer_done;
    logic [DUR_W-1:0]   timer_target;
    logic               advance;
    logic               end_song;

    assign rom_beats = rom_data[BEATS_LSB +: DUR_W];
    assign rom_pitch = rom_data[PITCH_LSB +: PITCH_W];

    assign timing       = (state == PLAY) || (state == GAP);
    assign tick_en      = beat_tick && !pause && timing;
    assign timer_target = (state == GAP) ? DUR_W'(GAP_BEATS) : note_beats;
    // Restart counting on every phase boundary so each note/gap starts at zero.
    assign timer_clear  = !timing || timer_done;

    note_timer #(
        .DUR_W (DUR_W)
    ) u_note_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .tick_en (tick_en),
        .target  (timer_target),
        .done    (timer_done)
    );

    always_comb begin
        state_n  = state;
        addr_n   = rom_addr;
        code_n   = note_code;
        on_n     = note_on;
        change_n = 1'b0;
        done_n   = 1'b0;
        beats_n  = note_beats;
        advance  = 1'b0;
        end_song = 1'b0;

        case (state)
            IDLE: begin
                if (play) begin
                    state_n = FETCH;
                    addr_n  = '0;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                if (rom_beats == DUR_W'(END_BEATS)) begin
                    end_song = 1'b1;
                end else begin
                    code_n   = rom_pitch;
                    on_n     = 1'b1;
                    change_n = 1'b1;
                    beats_n  = rom_beats;
                    state_n  = PLAY;
                end
            end
            PLAY: begin
                if (timer_done) begin
                    if (GAP_BEATS > 0) begin
                        on_n    = 1'b0;
                        state_n = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (timer_done) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Running off the top of the ROM ends the song rather than wrapping.
        if (advance) begin
            if (rom_addr == '1) begin
                end_song = 1'b1;
            end else begin
                addr_n  = rom_addr + ADDR_W'(1);
                state_n = FETCH;
            end
        end

        if (end_song) begin
            addr_n = '0;
            on_n   = 1'b0;
            if (loop_en) begin
                state_n = FETCH;
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end

        if (stop) begin
            state_n  = IDLE;
            addr_n   = '0;
            code_n   = '0;
            on_n     = 1'b0;
            change_n = 1'b0;
            done_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rom_addr    <= '0;
            note_code   <= '0;
            note_on     <= 1'b0;
            note_change <= 1'b0;
            song_done   <= 1'b0;
            note_beats  <= '0;
            playing     <= 1'b0;
        end else begin
            state       <= state_n;
            rom_addr    <= addr_n;
            note_code   <= code_n;
            note_on     <= on_n;
            note_change <= change_n;
            song_done   <= done_n;
            note_beats  <= beats_n;
            playing     <= (state_n != IDLE);
        end
    end

    // Pause mutes immediately but only while a note or gap is being timed.
    assign note_valid = note_on && !(pause && timing);

endmodule
